// File: rtl/alu_mc_if.sv
// alu_mc_if -- operand/result bundle for the multi-cycle ALU.
//   Input side : in_valid, in_ready, a, b, ALUcontrol
//   Output side: out_valid, out_ready, result, zero, neg, carry, ovf, err
//   master = producer of operations / consumer of results (datapath)
//   slave  = the ALU itself
interface alu_mc_if #(
  parameter int N = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   ALUcontrol;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         zero;
  logic         neg;
  logic         carry;
  logic         ovf;
  logic         err;

  modport master (
    output in_valid, a, b, ALUcontrol, out_ready,
    input  in_ready, out_valid, result, zero, neg, carry, ovf, err
  );

  modport slave (
    input  in_valid, a, b, ALUcontrol, out_ready,
    output in_ready, out_valid, result, zero, neg, carry, ovf, err
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc -- parametrised multi-cycle ALU with NZCV-style flags and
// valid/ready handshakes on both sides.
//   clk      : single clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : alu_mc_if.slave (operands/opcode in, registered result/flags out)
// Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 LSL, 0100 LSR, 0101 XOR,
//          0110 SUB, 0111 PASSB, 1000 MUL (iterative, N cycles). Others -> err.
module alu_mc #(
  parameter int N = 64
) (
  input  logic     clk,
  input  logic     reset_n,
  alu_mc_if.slave  bus
);
  localparam int SHW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   result_reg;
  logic           zero_reg, neg_reg, carry_reg, ovf_reg, err_reg;
  // Multiplicand is kept 2N wide so the high half of the product is available
  // for the MUL overflow flag.
  logic [2*N-1:0] mcand_reg;
  logic [2*N-1:0] acc_reg;
  logic [N-1:0]   mplier_reg;
  logic [SHW-1:0] cnt_reg;

  logic           accept;
  logic           is_mul;
  logic           mul_done;
  logic [N:0]     add_w;
  logic [N:0]     sub_w;
  logic [2*N-1:0] mul_next;
  logic [N-1:0]   op_res;
  logic           op_carry, op_ovf, op_err;

  assign accept   = bus.in_valid && (state_reg == S_IDLE);
  assign is_mul   = (bus.ALUcontrol == 4'b1000);
  assign mul_done = (state_reg == S_MUL) && (cnt_reg == SHW'(N - 1));
  assign add_w    = {1'b0, bus.a} + {1'b0, bus.b};
  // MSB of the widened difference is the borrow; carry is its inverse.
  assign sub_w    = {1'b0, bus.a} - {1'b0, bus.b};
  assign mul_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept) state_next = is_mul ? S_MUL : S_HOLD;
      S_MUL:  if (mul_done) state_next = S_HOLD;
      S_HOLD: if (bus.out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // Single-cycle operations
  always_comb begin
    op_res   = '0;
    op_carry = 1'b0;
    op_ovf   = 1'b0;
    op_err   = 1'b0;
    case (bus.ALUcontrol)
      4'b0000: op_res = bus.a & bus.b;
      4'b0001: op_res = bus.a | bus.b;
      4'b0010: begin
        op_res   = add_w[N-1:0];
        op_carry = add_w[N];
        op_ovf   = (bus.a[N-1] == bus.b[N-1]) && (add_w[N-1] != bus.a[N-1]);
      end
      4'b0011: op_res = bus.a << bus.b[SHW-1:0];
      4'b0100: op_res = bus.a >> bus.b[SHW-1:0];
      4'b0101: op_res = bus.a ^ bus.b;
      4'b0110: begin
        op_res   = sub_w[N-1:0];
        op_carry = ~sub_w[N];
        op_ovf   = (bus.a[N-1] != bus.b[N-1]) && (sub_w[N-1] != bus.a[N-1]);
      end
      4'b0111: op_res = bus.b;
      4'b1000: op_res = '0;  // handled by the iterative multiplier
      default: op_err = 1'b1;
    endcase
  end

  // Result/flag registers and shift-add multiplier
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_reg <= '0;
      zero_reg   <= 1'b0;
      neg_reg    <= 1'b0;
      carry_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
      err_reg    <= 1'b0;
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
    end else if (accept) begin
      if (is_mul) begin
        mcand_reg  <= {{N{1'b0}}, bus.a};
        mplier_reg <= bus.b;
        acc_reg    <= '0;
        cnt_reg    <= '0;
      end else begin
        result_reg <= op_res;
        zero_reg   <= (op_res == '0);
        neg_reg    <= op_res[N-1];
        carry_reg  <= op_carry;
        ovf_reg    <= op_ovf;
        err_reg    <= op_err;
      end
    end else if (state_reg == S_MUL) begin
      acc_reg    <= mul_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + 1'b1;
      if (mul_done) begin
        result_reg <= mul_next[N-1:0];
        zero_reg   <= (mul_next[N-1:0] == '0);
        neg_reg    <= mul_next[N-1];
        carry_reg  <= 1'b0;
        ovf_reg    <= |mul_next[2*N-1:N];
        err_reg    <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state_reg == S_IDLE);
  assign bus.out_valid = (state_reg == S_HOLD);
  assign bus.result    = result_reg;
  assign bus.zero      = zero_reg;
  assign bus.neg       = neg_reg;
  assign bus.carry     = carry_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.err       = err_reg;
endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_mc_if #(.N(64)) bus();

  alu_mc #(.N(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                         OP_LSL = 4'b0011, OP_LSR = 4'b0100, OP_XOR = 4'b0101,
                         OP_SUB = 4'b0110, OP_PASSB = 4'b0111, OP_MUL = 4'b1000;

  // Present one operation for a single edge (called at posedge+1 with DUT idle).
  task automatic issue(input logic [3:0] op, input logic [63:0] av, input logic [63:0] bv);
    bus.ALUcontrol = op;
    bus.a          = av;
    bus.b          = bv;
    bus.in_valid   = 1'b1;
    @(posedge clk); #1;
    bus.in_valid   = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic show(input string tag);
    $display("txn %s op=%b a=%h b=%h -> v=%b result=%h z=%b n=%b c=%b v=%b e=%b", tag,
             bus.ALUcontrol, bus.a, bus.b, bus.out_valid, bus.result,
             bus.zero, bus.neg, bus.carry, bus.ovf, bus.err);
  endtask

  // Single-cycle op followed by full result/flag comparison, then drained.
  task automatic test_single(input string tag, input logic [3:0] op, input logic [63:0] av,
                             input logic [63:0] bv, input logic [63:0] exp_res,
                             input logic [4:0] exp_zncve);
    logic [4:0] got;
    issue(op, av, bv);
    show(tag);
    got = {bus.zero, bus.neg, bus.carry, bus.ovf, bus.err};
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL %s out_valid: got %b want 1", tag, bus.out_valid);
    end
    n_cmp++;
    if (bus.result !== exp_res) begin
      n_bad++; $display("FAIL %s result: got %h want %h", tag, bus.result, exp_res);
    end
    n_cmp++;
    if (got !== exp_zncve) begin
      n_bad++; $display("FAIL %s flags zncve: got %b want %b", tag, got, exp_zncve);
    end
    drain();
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.ALUcontrol = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if ({bus.out_valid, bus.result, bus.zero, bus.neg, bus.carry, bus.ovf, bus.err} !== '0) begin
      n_bad++; $display("FAIL reset outputs: got v=%b r=%h f=%b%b%b%b%b want all 0", bus.out_valid,
                        bus.result, bus.zero, bus.neg, bus.carry, bus.ovf, bus.err);
    end
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready);
    end
    $display("txn reset released in_ready=%b", bus.in_ready);
    @(posedge clk); #1;
  endtask

  task automatic test_alu_ops();
    // flags order: zero neg carry ovf err
    test_single("sub_neg",  OP_SUB, 64'd2108, 64'd2669, 64'hFFFF_FFFF_FFFF_FDCF, 5'b01000);
    test_single("sub_pos",  OP_SUB, 64'd5, 64'd3, 64'd2, 5'b00100);
    test_single("sub_ovf",  OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 5'b00110);
    test_single("add_ovf",  OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 5'b01010);
    test_single("add_wrap", OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 5'b10100);
    test_single("or",       OP_OR,  64'hF0, 64'h0F, 64'hFF, 5'b00000);
    test_single("xor",      OP_XOR, 64'hFF, 64'h0F, 64'hF0, 5'b00000);
    test_single("lsr63",    OP_LSR, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 5'b00000);
    test_single("lsl_amt0", OP_LSL, 64'h1234, 64'd64, 64'h1234, 5'b00000);
    test_single("passb",    OP_PASSB, 64'd5, 64'hDEAD, 64'hDEAD, 5'b00000);
  endtask

  task automatic test_mul();
    int cyc;
    bit ready_seen;
    issue(OP_MUL, 64'd1206, 64'd4404);
    cyc = 0; ready_seen = 0;
    while (bus.out_valid !== 1'b1 && cyc < 80) begin
      if (bus.in_ready !== 1'b0) ready_seen = 1;
      if (cyc == 10) begin
        bus.ALUcontrol = OP_ADD; bus.a = 64'd1; bus.b = 64'd1; bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.ALUcontrol = OP_MUL; bus.a = 64'd1206; bus.b = 64'd4404;
    show("mul");
    n_cmp++;
    if (cyc !== 64) begin
      n_bad++; $display("FAIL mul latency: got %0d cycles want 64", cyc);
    end
    n_cmp++;
    if (ready_seen) begin
      n_bad++; $display("FAIL mul in_ready during MUL: got 1 want 0");
    end
    n_cmp++;
    if (bus.result !== 64'd5311224) begin
      n_bad++; $display("FAIL mul result: got %0d want 5311224", bus.result);
    end
    n_cmp++;
    if ({bus.zero, bus.neg, bus.carry, bus.ovf, bus.err} !== 5'b00000) begin
      n_bad++; $display("FAIL mul flags: got %b want 00000",
                        {bus.zero, bus.neg, bus.carry, bus.ovf, bus.err});
    end
    drain();

    issue(OP_MUL, 64'h1_0000_0000, 64'h1_0000_0000);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
    end
    show("mul_ovf");
    n_cmp++;
    if (cyc !== 64) begin
      n_bad++; $display("FAIL mul_ovf latency: got %0d want 64", cyc);
    end
    n_cmp++;
    if ({bus.result, bus.zero, bus.neg, bus.carry, bus.ovf, bus.err} !== {64'd0, 5'b10010}) begin
      n_bad++; $display("FAIL mul_ovf: got r=%h f=%b want r=0 f=10010", bus.result,
                        {bus.zero, bus.neg, bus.carry, bus.ovf, bus.err});
    end
    drain();
  endtask

  task automatic test_back_to_back();
    bit unstable;
    issue(OP_ADD, 64'd3, 64'd4);
    unstable = 0;
    repeat (5) begin
      if (bus.result !== 64'd7 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.zero !== 1'b0 || bus.carry !== 1'b0) unstable = 1;
      @(posedge clk); #1;
    end
    show("add_hold");
    n_cmp++;
    if (unstable || bus.result !== 64'd7 || bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL backpressure hold: got r=%0d v=%b want r=7 v=1 stable", bus.result,
                        bus.out_valid);
    end
    // Output handshake with a new operation offered in the same cycle: must not bypass.
    bus.ALUcontrol = OP_AND; bus.a = 64'd1206; bus.b = 64'd4404;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL no_bypass: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    show("and_b2b");
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.result !== 64'd52) begin
      n_bad++; $display("FAIL and_b2b: got v=%b r=%0d want v=1 r=52", bus.out_valid, bus.result);
    end
    drain();
  endtask

  task automatic test_reset_mid_mul();
    bit rose;
    issue(OP_MUL, 64'd1206, 64'd4404);
    repeat (20) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    show("reset_mid_mul");
    n_cmp++;
    if ({bus.out_valid, bus.result, bus.zero, bus.neg, bus.carry, bus.ovf, bus.err} !== '0) begin
      n_bad++; $display("FAIL reset_mid_mul outputs: got v=%b r=%h want all 0", bus.out_valid,
                        bus.result);
    end
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    rose = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) rose = 1;
    end
    n_cmp++;
    if (rose) begin
      n_bad++; $display("FAIL reset_mid_mul out_valid: got 1 want 0 after abort");
    end
    test_single("lsl_amt3", OP_LSL, 64'd1, 64'd67, 64'd8, 5'b00000);
  endtask

  task automatic test_illegal();
    test_single("illegal", 4'b1111, 64'd5, 64'd7, 64'd0, 5'b10001);
    test_single("after_illegal", OP_OR, 64'd5, 64'd7, 64'd7, 5'b00000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_ops();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
